interp_sched: RTL and testbench

Rate controller for the zero-stuffing interpolator datapath. It pulls input samples through a valid/ready handshake and sequences a programmable L-phase output frame (L = 1..16), one output slot per clock. Phase 0 of each frame carries the sample; all other phases carry zero. It also handles start/stop, underrun detection and frame-boundary strobes, and sits between the baseband sample source and the downstream interpolation FIR.

---
 rtl/interp_sched.sv | 129 ++++++++++++
 tb/tb_interp_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_sched.sv
// Rate controller for a zero-stuffing interpolator: pulls one sample per L-slot frame
// over valid/ready and emits a gap-free stream of output slots (sample on phase 0, zeros elsewhere).
module interp_sched #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    ratio_cfg,
    input  logic          cfg_load,
    input  logic          enable,
    input  logic          cnt_clr,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_phase,
    output logic          out_first,
    output logic          underrun,
    output logic [CW-1:0] underrun_cnt,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t        state, state_next;
    logic [3:0]    ratio_q;
    logic [3:0]    phase;
    logic [DW-1:0] hold;
    logic          hold_ok;
    logic          last;
    logic          take;
    logic          miss;

    assign last = (phase == ratio_q);
    assign take = in_valid && in_ready;
    // A phase-0 slot without a held sample is the visible symptom of a missed fetch.
    assign miss = (state == RUN) && (phase == 4'd0) && !hold_ok;
    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = PRIME;
            end
            PRIME: begin
                in_ready = enable;
                if (!enable)       state_next = IDLE;
                else if (in_valid) state_next = RUN;
            end
            RUN: begin
                // enable is only honoured at the frame boundary, so frames always complete.
                if (last) begin
                    in_ready = enable;
                    if (!enable) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ratio_q      <= 4'd3;
            phase        <= 4'd0;
            hold         <= '0;
            hold_ok      <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_phase    <= 4'd0;
            out_first    <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= miss;
            if (cnt_clr)
                underrun_cnt <= '0;
            else if (miss && (underrun_cnt != {CW{1'b1}}))
                underrun_cnt <= underrun_cnt + CW'(1);

            case (state)
                RUN: begin
                    out_valid <= 1'b1;
                    out_phase <= phase;
                    out_first <= (phase == 4'd0);
                    out_data  <= ((phase == 4'd0) && hold_ok) ? hold : '0;
                    phase     <= last ? 4'd0 : phase + 4'd1;
                    if (last && enable) begin
                        if (in_valid) begin
                            hold    <= in_data;
                            hold_ok <= 1'b1;
                        end else begin
                            hold_ok <= 1'b0;
                        end
                    end
                end
                PRIME: begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_phase <= 4'd0;
                    out_first <= 1'b0;
                    if (take) begin
                        hold    <= in_data;
                        hold_ok <= 1'b1;
                        phase   <= 4'd0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_phase <= 4'd0;
                    out_first <= 1'b0;
                    if (cfg_load) ratio_q <= ratio_cfg;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interp_sched.sv
// Scoreboard bench for interp_sched: accepted samples push expected frames into a queue,
// a negedge monitor pops and compares every valid output slot.
module tb_interp_sched;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] phase;
        logic       first;
    } slot_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] ratio_cfg = 4'd0;
    logic       cfg_load = 1'b0;
    logic       enable = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [3:0] out_phase;
    logic       out_first;
    logic       underrun;
    logic [7:0] underrun_cnt;
    logic       busy;

    interp_sched #(.DW(8), .CW(8)) dut (
        .clk(clk), .reset(reset), .ratio_cfg(ratio_cfg), .cfg_load(cfg_load),
        .enable(enable), .cnt_clr(cnt_clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_phase(out_phase), .out_first(out_first), .underrun(underrun),
        .underrun_cnt(underrun_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    n_hs = 0;
    int    ur_pulses = 0;
    int    ready_gaps = 0;
    int    cur_len = 4;
    int    xfer_cyc = 0;
    int    first_valid_cyc = 0;
    bit    got_xfer = 1'b0;
    bit    got_valid = 1'b0;
    bit    sb_en = 1'b1;
    bit    pt_chk = 1'b0;
    logic [7:0] src_inc = 8'h00;
    slot_t exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input int len);
        for (int p = 0; p < len; p++) begin
            slot_t s;
            s.data  = (p == 0) ? d : 8'h00;
            s.phase = 4'(p);
            s.first = (p == 0);
            exp_q.push_back(s);
        end
    endtask

    // Monitor: every valid slot must match the head of the expected queue.
    always @(negedge clk) begin
        if (underrun) ur_pulses++;
        if (out_valid && !got_valid) begin
            got_valid = 1'b1;
            first_valid_cyc = cyc;
        end
        if (sb_en && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_slot", {out_data, out_phase, out_first}, 32'h0);
            end else begin
                slot_t e;
                e = exp_q.pop_front();
                check("slot", {19'd0, out_data, out_phase, out_first}, {19'd0, e});
            end
            if (underrun)
                check("underrun_on_zero_slot", {out_first, out_data}, {1'b1, 8'h00});
        end
    end

    // One clock: observe the handshake mid-cycle, then advance inputs just after the edge.
    task automatic step();
        bit hs;
        @(negedge clk);
        hs = in_valid && in_ready;
        if (pt_chk && enable && busy && !in_ready) ready_gaps++;
        if (hs) begin
            n_hs++;
            if (!got_xfer) begin
                got_xfer = 1'b1;
                xfer_cyc = cyc;
            end
            if (sb_en) push_frame(in_data, cur_len);
        end
        @(posedge clk);
        #1;
        if (hs) in_data = in_data + src_inc;
    endtask

    task automatic wait_hs(input int k);
        int target;
        target = n_hs + k;
        for (int i = 0; i < 200 && n_hs < target; i++) step();
        check("handshake_count", n_hs, target);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (busy || out_valid); i++) step();
        check("idle_reached", {busy, out_valid}, 0);
        step();
        step();
    endtask

    task automatic do_reset();
        enable = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
        n_hs = 0; ur_pulses = 0; got_xfer = 1'b0; got_valid = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with run and load requests held to show reset dominates.
        reset = 1'b1; enable = 1'b1; cfg_load = 1'b1; ratio_cfg = 4'd9; in_valid = 1'b1;
        step();
        step();
        check("reset_outputs", {out_valid, out_data, out_phase, out_first, underrun},
              32'h0);
        check("reset_cnt_busy_ready", {underrun_cnt, busy, in_ready}, 32'h0);

        // Default ratio x4: 11,0,0,0,22,0,0,0,33,0,0,0 and first slot 2 cycles after transfer.
        do_reset();
        cur_len = 4; src_inc = 8'h11; in_data = 8'h11; in_valid = 1'b1; enable = 1'b1;
        wait_hs(3);
        enable = 1'b0;
        wait_idle();
        check("first_valid_latency", first_valid_cyc - xfer_cyc, 2);
        check("x4_queue_drained", exp_q.size(), 0);

        // Pass-through, load and enable in the same cycle; ramp source.
        do_reset();
        cfg_load = 1'b1; ratio_cfg = 4'd0; enable = 1'b1;
        in_data = 8'h40; src_inc = 8'h01; in_valid = 1'b1; cur_len = 1;
        pt_chk = 1'b1; ready_gaps = 0;
        step();
        cfg_load = 1'b0;
        wait_hs(8);
        enable = 1'b0;
        pt_chk = 1'b0;
        wait_idle();
        check("pt_first_latency", first_valid_cyc - xfer_cyc, 2);
        check("pt_ready_gaps", ready_gaps, 0);
        check("pt_queue_drained", exp_q.size(), 0);

        // x16 with one missed fetch: sample frame, 16-slot zero frame, then next sample.
        do_reset();
        cfg_load = 1'b1; ratio_cfg = 4'd15;
        step();
        cfg_load = 1'b0;
        cur_len = 16; src_inc = 8'h00; in_data = 8'hA5; in_valid = 1'b1; enable = 1'b1;
        wait_hs(1);
        in_valid = 1'b0;
        push_frame(8'h00, 16);
        repeat (16) step();
        in_valid = 1'b1; in_data = 8'h5A;
        wait_hs(1);
        enable = 1'b0;
        wait_idle();
        check("x16_underrun_pulses", ur_pulses, 1);
        check("x16_underrun_cnt", underrun_cnt, 1);
        check("x16_queue_drained", exp_q.size(), 0);

        // enable falls at phase 1: phases 2 and 3 still emitted, no fetch at phase 3.
        do_reset();
        cur_len = 4; src_inc = 8'h00; in_data = 8'h77; in_valid = 1'b1; enable = 1'b1;
        wait_hs(1);
        step();
        check("drop_at_phase1", out_phase, 0);
        enable = 1'b0;
        wait_idle();
        check("drop_no_extra_xfer", n_hs, 1);
        check("drop_busy_low", busy, 0);
        check("drop_queue_drained", exp_q.size(), 0);

        // cfg_load mid-RUN is ignored; the same load in IDLE takes effect.
        do_reset();
        cur_len = 4; src_inc = 8'h10; in_data = 8'h10; in_valid = 1'b1; enable = 1'b1;
        wait_hs(1);
        cfg_load = 1'b1; ratio_cfg = 4'd7;
        step();
        cfg_load = 1'b0;
        wait_hs(1);
        enable = 1'b0;
        wait_idle();
        check("cfg_run_ignored_drained", exp_q.size(), 0);
        cfg_load = 1'b1; ratio_cfg = 4'd7;
        step();
        cfg_load = 1'b0;
        cur_len = 8; enable = 1'b1;
        wait_hs(2);
        enable = 1'b0;
        wait_idle();
        check("cfg_idle_x8_drained", exp_q.size(), 0);

        // Reset mid-RUN at ratio 7: outputs clear at once and the ratio returns to 3.
        enable = 1'b1;
        wait_hs(1);
        repeat (3) step();
        sb_en = 1'b0;
        enable = 1'b0;
        reset = 1'b1;
        step();
        check("midrun_reset_outputs", {out_valid, out_data, out_phase, out_first, underrun},
              32'h0);
        check("midrun_reset_state", {busy, in_ready, underrun_cnt}, 32'h0);
        reset = 1'b0;
        step();
        exp_q.delete();
        sb_en = 1'b1;
        cur_len = 4; src_inc = 8'h00; in_data = 8'h99; enable = 1'b1;
        wait_hs(1);
        enable = 1'b0;
        wait_idle();
        check("post_reset_x4_drained", exp_q.size(), 0);

        // Saturation: continuous underruns in pass-through, then clear against an increment.
        do_reset();
        sb_en = 1'b0;
        cfg_load = 1'b1; ratio_cfg = 4'd0; enable = 1'b1; in_valid = 1'b1; in_data = 8'h01;
        step();
        cfg_load = 1'b0;
        wait_hs(1);
        in_valid = 1'b0;
        repeat (310) step();
        check("sat_pulses_300", ur_pulses >= 300, 1);
        check("sat_cnt", underrun_cnt, 255);
        cnt_clr = 1'b1;
        step();
        check("clr_coincident_underrun", underrun, 1);
        check("clr_wins", underrun_cnt, 0);
        cnt_clr = 1'b0;
        step();
        check("cnt_after_clr", underrun_cnt, 1);
        enable = 1'b0;
        wait_idle();
        sb_en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
